// File: rtl/pci_bus_arbiter_if.sv
// Bus-side signal bundle for the central PCI arbiter: per-master req/gnt plus the
// shared FRAME#/IRDY# lines it observes. All bus lines are active-low.
interface pci_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W     = 2
);
    logic [NUM_MASTERS-1:0] req;
    logic                   frame;
    logic                   irdy;
    logic [NUM_MASTERS-1:0] gnt;
    logic [OWNER_W-1:0]     owner;
    logic                   owner_valid;
    logic                   timeout;

    // master: the arbiter itself, which masters the grant lines; slave: the bus side.
    modport master (
        input  req, frame, irdy,
        output gnt, owner, owner_valid, timeout
    );

    modport slave (
        output req, frame, irdy,
        input  gnt, owner, owner_valid, timeout
    );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Central round-robin PCI arbiter with hidden re-arbitration, a one-cycle all-high
// gap between grantees, and a grant-to-FRAME# timeout for silent masters.
module pci_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W     = 2,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    pci_bus_arbiter_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    localparam int                 CNT_W     = $clog2(GNT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(GNT_TIMEOUT - 1);
    localparam logic [OWNER_W-1:0] LAST_INIT = OWNER_W'(NUM_MASTERS - 1);

    logic [1:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [OWNER_W-1:0]     last_owner_q, last_owner_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;
    logic                   bus_idle_q;

    logic                   bus_idle;
    logic                   start;
    logic                   owner_req;
    logic                   others_req;
    logic [NUM_MASTERS-1:0] owner_mask;
    logic                   win_found;
    logic [OWNER_W-1:0]     win_idx;
    logic [OWNER_W-1:0]     cand;

    assign bus_idle   = bus.frame & bus.irdy;
    // Only a FRAME# fall that follows an idle cycle belongs to the current owner.
    assign start      = bus_idle_q & ~bus.frame;
    assign owner_mask = NUM_MASTERS'(1) << owner_q;
    assign owner_req  = ~bus.req[owner_q];
    assign others_req = |(~bus.req & ~owner_mask);

    // Round-robin search starting just after the most recent grantee.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        win_found = 1'b0;
        win_idx   = last_owner_q;
        cand      = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = OWNER_W'((int'(last_owner_q) + i) % NUM_MASTERS);
            if (!win_found && !bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        timeout_d    = 1'b0;

        case (state_q)
            // GAP lasts one cycle and then arbitrates exactly like IDLE.
            IDLE, GAP: begin
                gnt_d   = '1;
                state_d = IDLE;
                if (win_found) begin
                    state_d      = GRANT;
                    gnt_d        = ~(NUM_MASTERS'(1) << win_idx);
                    owner_d      = win_idx;
                    last_owner_d = win_idx;
                    cnt_d        = '0;
                end
            end

            GRANT: begin
                if (start) begin
                    state_d = BUSY;
                end else if (!owner_req) begin
                    state_d = GAP;
                    gnt_d   = '1;
                end else if (bus_idle) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d   = GAP;
                        gnt_d     = '1;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            BUSY: begin
                if (others_req) begin
                    // Hidden arbitration: owner keeps FRAME# and finishes its cycle.
                    state_d = GAP;
                    gnt_d   = '1;
                end else if (bus_idle) begin
                    if (owner_req) begin
                        state_d = GRANT;
                        cnt_d   = '0;
                    end else begin
                        state_d = GAP;
                        gnt_d   = '1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '1;
            owner_q      <= '0;
            last_owner_q <= LAST_INIT;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            bus_idle_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            bus_idle_q   <= bus_idle;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.owner       = owner_q;
    assign bus.owner_valid = ~&gnt_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter: each cycle pushes its expected outputs to a
// scoreboard queue, which is popped and compared one time unit after the edge.
module tb_pci_bus_arbiter;
    localparam int NM = 4;
    localparam int OW = 2;
    localparam int TO = 16;

    typedef struct packed {
        logic [NM-1:0] gnt;
        logic [OW-1:0] owner;
        logic          timeout;
    } exp_t;

    logic clk;
    logic rst;

    pci_bus_arbiter_if #(.NUM_MASTERS(NM), .OWNER_W(OW)) bus ();

    pci_bus_arbiter #(
        .NUM_MASTERS(NM),
        .OWNER_W    (OW),
        .GNT_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    string         phase    = "init";
    logic [NM-1:0] prev_gnt = '1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bus clock: drive inputs, queue the expected post-edge outputs, then compare.
    task automatic cyc(input logic r, input logic [NM-1:0] rq, input logic f, input logic i,
                       input logic [NM-1:0] eg, input logic [OW-1:0] eo, input logic et);
        exp_t e;
        rst       = r;
        bus.req   = rq;
        bus.frame = f;
        bus.irdy  = i;
        exp_q.push_back('{gnt: eg, owner: eo, timeout: et});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({phase, "/gnt"}, 32'(bus.gnt), 32'(e.gnt));
        check({phase, "/owner"}, 32'(bus.owner), 32'(e.owner));
        check({phase, "/owner_valid"}, 32'(bus.owner_valid), 32'(e.gnt != '1));
        check({phase, "/timeout"}, 32'(bus.timeout), 32'(e.timeout));
        check({phase, "/one_gnt"}, 32'($countones(~bus.gnt) <= 1), 32'(1));
        check({phase, "/gap"},
              32'((prev_gnt != '1) && (bus.gnt != '1) && (prev_gnt != bus.gnt)), 32'(0));
        prev_gnt = bus.gnt;
    endtask

    initial begin
        int            order[5];
        logic [NM-1:0] g;
        order = '{0, 1, 2, 3, 0};

        rst       = 1'b1;
        bus.req   = '1;
        bus.frame = 1'b1;
        bus.irdy  = 1'b1;

        phase = "reset";
        cyc(1, 4'b1111, 1, 1, 4'b1111, 2'd0, 0);

        // Single request: grant latency, start detection, return to GRANT.
        phase = "basic";
        cyc(0, 4'b1110, 1, 1, 4'b1110, 2'd0, 0);
        cyc(0, 4'b1110, 1, 1, 4'b1110, 2'd0, 0);
        cyc(0, 4'b1110, 0, 1, 4'b1110, 2'd0, 0);
        cyc(0, 4'b1110, 0, 0, 4'b1110, 2'd0, 0);
        cyc(0, 4'b1110, 1, 0, 4'b1110, 2'd0, 0);
        cyc(0, 4'b1110, 1, 1, 4'b1110, 2'd0, 0);
        cyc(0, 4'b1111, 1, 1, 4'b1111, 2'd0, 0);
        cyc(0, 4'b1111, 1, 1, 4'b1111, 2'd0, 0);
        cyc(0, 4'b1111, 1, 1, 4'b1111, 2'd0, 0);

        // Everyone requesting: round-robin 0,1,2,3,0 with one gap cycle each.
        phase = "rr_reset";
        cyc(1, 4'b1111, 1, 1, 4'b1111, 2'd0, 0);
        phase = "round_robin";
        for (int k = 0; k < 5; k++) begin
            g = ~(NM'(1) << order[k]);
            cyc(0, 4'b0000, 1, 1, g, OW'(order[k]), 0);
            cyc(0, 4'b0000, 0, 0, g, OW'(order[k]), 0);
            cyc(0, 4'b0000, 1, 1, 4'b1111, OW'(order[k]), 0);
        end
        cyc(0, 4'b1111, 1, 1, 4'b1111, 2'd0, 0);

        // Master 2 never drives FRAME#: grant revoked after TO idle cycles.
        phase = "timeout";
        for (int k = 0; k < TO; k++)
            cyc(0, 4'b1011, 1, 1, 4'b1011, 2'd2, 0);
        cyc(0, 4'b1011, 1, 1, 4'b1111, 2'd2, 1);
        cyc(0, 4'b1011, 1, 1, 4'b1011, 2'd2, 0);
        cyc(0, 4'b1011, 1, 1, 4'b1011, 2'd2, 0);
        cyc(0, 4'b1111, 1, 1, 4'b1111, 2'd2, 0);
        cyc(0, 4'b1111, 1, 1, 4'b1111, 2'd2, 0);

        // Hidden arbitration while master 0 is busy; master 1 granted under FRAME#.
        phase = "hidden";
        cyc(0, 4'b1110, 1, 1, 4'b1110, 2'd0, 0);
        cyc(0, 4'b1110, 0, 1, 4'b1110, 2'd0, 0);
        cyc(0, 4'b1100, 0, 1, 4'b1111, 2'd0, 0);
        cyc(0, 4'b1100, 0, 1, 4'b1101, 2'd1, 0);
        // Carried-over FRAME# low must not count as master 1's start.
        cyc(0, 4'b1100, 0, 1, 4'b1101, 2'd1, 0);
        cyc(0, 4'b1100, 0, 0, 4'b1101, 2'd1, 0);
        cyc(0, 4'b1100, 1, 1, 4'b1101, 2'd1, 0);
        cyc(0, 4'b1100, 0, 1, 4'b1101, 2'd1, 0);
        cyc(0, 4'b1100, 0, 1, 4'b1111, 2'd1, 0);
        cyc(0, 4'b1111, 1, 1, 4'b1111, 2'd1, 0);

        // Master 3 withdraws before FRAME#: GAP then IDLE, no timeout.
        phase = "withdraw";
        cyc(0, 4'b0111, 1, 1, 4'b0111, 2'd3, 0);
        cyc(0, 4'b0111, 1, 1, 4'b0111, 2'd3, 0);
        cyc(0, 4'b1111, 1, 1, 4'b1111, 2'd3, 0);
        cyc(0, 4'b1111, 1, 1, 4'b1111, 2'd3, 0);
        cyc(0, 4'b1111, 1, 1, 4'b1111, 2'd3, 0);

        // Reset mid-transaction, then master 0 wins first again.
        phase = "rst_busy";
        cyc(0, 4'b1011, 1, 1, 4'b1011, 2'd2, 0);
        cyc(0, 4'b1011, 0, 0, 4'b1011, 2'd2, 0);
        cyc(1, 4'b1011, 0, 0, 4'b1111, 2'd0, 0);
        cyc(0, 4'b0000, 1, 1, 4'b1110, 2'd0, 0);
        cyc(0, 4'b1111, 1, 1, 4'b1111, 2'd0, 0);
        cyc(0, 4'b1111, 1, 1, 4'b1111, 2'd0, 0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
